// File: rtl/lc3_execute.sv
// rtl/lc3_execute.sv - LC3 execute stage: operand bypass, ALU, address adder, branch mask
//
// Ports:
//   clock, reset (sync, active-low), enable_execute (stage advance)
//   E_control      {alu_control[5:4], pcselect1[3:2], pcselect2[1], op2select[0]}
//   bypass_alu_1/2, bypass_mem_1/2  operand forwarding selects
//   IR, npc_in, VSR1, VSR2, Mem_Bypass_Val  data inputs
//   Mem_Control_in, W_Control_in    downstream control, forwarded
//   aluout, pcout, M_Data, W_Control_out, Mem_Control_out, IR_Exec, dr, NZP  registered
//   sr1, sr2       combinational register-file read addresses

module lc3_execute (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_execute,
    input  logic [5:0]  E_control,
    input  logic        bypass_alu_1,
    input  logic        bypass_alu_2,
    input  logic        bypass_mem_1,
    input  logic        bypass_mem_2,
    input  logic [15:0] IR,
    input  logic [15:0] npc_in,
    input  logic        Mem_Control_in,
    input  logic [1:0]  W_Control_in,
    input  logic [15:0] VSR1,
    input  logic [15:0] VSR2,
    input  logic [15:0] Mem_Bypass_Val,
    output logic [15:0] aluout,
    output logic [15:0] pcout,
    output logic [15:0] M_Data,
    output logic [1:0]  W_Control_out,
    output logic        Mem_Control_out,
    output logic [15:0] IR_Exec,
    output logic [2:0]  dr,
    output logic [2:0]  NZP,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2
);

    logic [1:0]  w_alu_control;
    logic [1:0]  w_pcselect1;
    logic        w_pcselect2;
    logic        w_op2select;
    logic [3:0]  w_opcode;
    logic [15:0] w_val1;
    logic [15:0] w_val2;
    logic [15:0] w_op2;
    logic [15:0] w_alu;
    logic [15:0] w_base;
    logic [15:0] w_offset;
    logic [15:0] w_addr;
    logic        w_is_alu_op;
    logic [2:0]  w_nzp;

    assign w_alu_control = E_control[5:4];
    assign w_pcselect1   = E_control[3:2];
    assign w_pcselect2   = E_control[1];
    assign w_op2select   = E_control[0];
    assign w_opcode      = IR[15:12];

    // Stores read the source data register from the DR field.
    assign sr1 = IR[8:6];
    assign sr2 = (w_opcode == 4'b0011 || w_opcode == 4'b0111 || w_opcode == 4'b1011)
               ? IR[11:9] : IR[2:0];

    // The alu path reads the aluout register before this edge, i.e. the
    // previous instruction's result, and takes priority over the mem path.
    assign w_val1 = bypass_alu_1 ? aluout : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
    assign w_val2 = bypass_alu_2 ? aluout : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);

    assign w_op2 = w_op2select ? w_val2 : {{11{IR[4]}}, IR[4:0]};

    always_comb begin
        w_alu = 16'h0000;
        case (w_alu_control)
            2'b00:   w_alu = w_val1 + w_op2;
            2'b01:   w_alu = w_val1 & w_op2;
            2'b10:   w_alu = ~w_val1;
            default: w_alu = w_val1;
        endcase
    end

    always_comb begin
        w_offset = 16'h0000;
        case (w_pcselect1)
            2'b00:   w_offset = {{5{IR[10]}}, IR[10:0]};
            2'b01:   w_offset = {{7{IR[8]}}, IR[8:0]};
            2'b10:   w_offset = {{10{IR[5]}}, IR[5:0]};
            default: w_offset = 16'h0000;
        endcase
    end

    assign w_base = w_pcselect2 ? npc_in : w_val1;
    assign w_addr = w_base + w_offset;

    assign w_is_alu_op = (w_opcode == 4'b0001) || (w_opcode == 4'b0101) || (w_opcode == 4'b1001);

    always_comb begin
        w_nzp = 3'b000;
        if (w_opcode == 4'b0000)
            w_nzp = IR[11:9];
        else if (w_opcode == 4'b1100)
            w_nzp = 3'b111;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            aluout          <= 16'h0000;
            pcout           <= 16'h0000;
            M_Data          <= 16'h0000;
            W_Control_out   <= 2'b00;
            Mem_Control_out <= 1'b0;
            IR_Exec         <= 16'h0000;
            dr              <= 3'b000;
            NZP             <= 3'b000;
        end else if (enable_execute) begin
            aluout          <= w_is_alu_op ? w_alu : w_addr;
            pcout           <= w_addr;
            M_Data          <= w_val2;
            W_Control_out   <= W_Control_in;
            Mem_Control_out <= Mem_Control_in;
            IR_Exec         <= IR;
            dr              <= IR[11:9];
            NZP             <= w_nzp;
        end else begin
            // A stalled branch must not be seen as taken on a second cycle.
            NZP             <= 3'b000;
        end
    end

endmodule

// File: tb/tb_lc3_execute.sv
// tb/tb_lc3_execute.sv - directed vector bench for lc3_execute

module tb_lc3_execute;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_execute;
    logic [5:0]  E_control;
    logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
    logic [15:0] IR, npc_in, VSR1, VSR2, Mem_Bypass_Val;
    logic        Mem_Control_in;
    logic [1:0]  W_Control_in;
    logic [15:0] aluout, pcout, M_Data, IR_Exec;
    logic [1:0]  W_Control_out;
    logic        Mem_Control_out;
    logic [2:0]  dr, NZP, sr1, sr2;

    int n_pass = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    lc3_execute dut (
        .clock(clock), .reset(reset), .enable_execute(enable_execute),
        .E_control(E_control),
        .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
        .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
        .IR(IR), .npc_in(npc_in),
        .Mem_Control_in(Mem_Control_in), .W_Control_in(W_Control_in),
        .VSR1(VSR1), .VSR2(VSR2), .Mem_Bypass_Val(Mem_Bypass_Val),
        .aluout(aluout), .pcout(pcout), .M_Data(M_Data),
        .W_Control_out(W_Control_out), .Mem_Control_out(Mem_Control_out),
        .IR_Exec(IR_Exec), .dr(dr), .NZP(NZP), .sr1(sr1), .sr2(sr2)
    );

    typedef struct {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  ec;
        logic [3:0]  byp;   // {alu_1, mem_1, alu_2, mem_2}
        logic [15:0] vsr1;
        logic [15:0] vsr2;
        logic [15:0] mbv;
        logic        mem;
        logic [1:0]  wc;
        logic [15:0] e_alu;
        logic [15:0] e_pc;
        logic [15:0] e_md;
        logic [2:0]  e_nzp;
        logic [2:0]  e_dr;
        logic [2:0]  e_sr1;
        logic [2:0]  e_sr2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [15:0] ir, input logic [15:0] npc, input logic [5:0] ec,
                                input logic [3:0] byp, input logic [15:0] vsr1, input logic [15:0] vsr2,
                                input logic [15:0] mbv, input logic mem, input logic [1:0] wc,
                                input logic [15:0] e_alu, input logic [15:0] e_pc, input logic [15:0] e_md,
                                input logic [2:0] e_nzp, input logic [2:0] e_dr,
                                input logic [2:0] e_sr1, input logic [2:0] e_sr2);
        vec_t v;
        v.ir = ir; v.npc = npc; v.ec = ec; v.byp = byp; v.vsr1 = vsr1; v.vsr2 = vsr2;
        v.mbv = mbv; v.mem = mem; v.wc = wc; v.e_alu = e_alu; v.e_pc = e_pc; v.e_md = e_md;
        v.e_nzp = e_nzp; v.e_dr = e_dr; v.e_sr1 = e_sr1; v.e_sr2 = e_sr2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        IR = v.ir; npc_in = v.npc; E_control = v.ec;
        {bypass_alu_1, bypass_mem_1, bypass_alu_2, bypass_mem_2} = v.byp;
        VSR1 = v.vsr1; VSR2 = v.vsr2; Mem_Bypass_Val = v.mbv;
        Mem_Control_in = v.mem; W_Control_in = v.wc;
    endtask

    task automatic randomize_inputs();
        E_control = 6'($urandom); npc_in = 16'($urandom);
        {bypass_alu_1, bypass_mem_1, bypass_alu_2, bypass_mem_2} = 4'($urandom);
        VSR1 = 16'($urandom); VSR2 = 16'($urandom); Mem_Bypass_Val = 16'($urandom);
        Mem_Control_in = 1'b1; W_Control_in = 2'b11;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".aluout"}, aluout, 16'h0000);
        chk({tag, ".pcout"}, pcout, 16'h0000);
        chk({tag, ".M_Data"}, M_Data, 16'h0000);
        chk({tag, ".W_Control_out"}, {14'h0, W_Control_out}, 16'h0000);
        chk({tag, ".Mem_Control_out"}, {15'h0, Mem_Control_out}, 16'h0000);
        chk({tag, ".IR_Exec"}, IR_Exec, 16'h0000);
        chk({tag, ".dr"}, {13'h0, dr}, 16'h0000);
        chk({tag, ".NZP"}, {13'h0, NZP}, 16'h0000);
    endtask

    initial begin
        //            ir       npc      ec         byp      vsr1     vsr2     mbv     mem  wc     alu      pc       md      nzp     dr sr1 sr2
        vecs.push_back(mk(16'h1042, 16'h0000, 6'b000001, 4'b0000, 16'h0005, 16'h0003, 16'h0000, 1'b1, 2'b01, 16'h0008, 16'h0047, 16'h0003, 3'b000, 3'd0, 3'd1, 3'd2));
        vecs.push_back(mk(16'h1042, 16'h0000, 6'b000001, 4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 2'b10, 16'h0000, 16'h0041, 16'h0001, 3'b000, 3'd0, 3'd1, 3'd2));
        vecs.push_back(mk(16'h127F, 16'h0000, 6'b000000, 4'b0000, 16'h0000, 16'h1234, 16'h0000, 1'b1, 2'b11, 16'hFFFF, 16'h027F, 16'h1234, 3'b000, 3'd1, 3'd1, 3'd7));
        vecs.push_back(mk(16'h1042, 16'h0000, 6'b000001, 4'b1101, 16'h5555, 16'h7777, 16'h0010, 1'b0, 2'b00, 16'h000F, 16'h0041, 16'h0010, 3'b000, 3'd0, 3'd1, 3'd2));
        vecs.push_back(mk(16'h5262, 16'h0000, 6'b010000, 4'b0000, 16'h00F3, 16'hAAAA, 16'h0000, 1'b1, 2'b01, 16'h0002, 16'h0355, 16'hAAAA, 3'b000, 3'd1, 3'd1, 3'd2));
        vecs.push_back(mk(16'h9A7F, 16'h0000, 6'b100000, 4'b0000, 16'h0F0F, 16'h0000, 16'h0000, 1'b0, 2'b10, 16'hF0F0, 16'h118E, 16'h0000, 3'b000, 3'd5, 3'd1, 3'd7));
        vecs.push_back(mk(16'hC1C0, 16'h0000, 6'b001100, 4'b0000, 16'h3456, 16'h0000, 16'h0000, 1'b0, 2'b00, 16'h3456, 16'h3456, 16'h0000, 3'b111, 3'd0, 3'd7, 3'd0));
        vecs.push_back(mk(16'h1000, 16'h0000, 6'b110000, 4'b0000, 16'hABCD, 16'h0000, 16'h0000, 1'b1, 2'b11, 16'hABCD, 16'hABCD, 16'h0000, 3'b000, 3'd0, 3'd0, 3'd0));
        vecs.push_back(mk(16'h0BFF, 16'h3000, 6'b000110, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00, 16'h2FFF, 16'h2FFF, 16'h0000, 3'b101, 3'd5, 3'd7, 3'd7));
        vecs.push_back(mk(16'hE7FE, 16'h1000, 6'b000010, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b01, 16'h0FFE, 16'h0FFE, 16'h0000, 3'b000, 3'd3, 3'd7, 3'd6));
        vecs.push_back(mk(16'h1042, 16'h0000, 6'b000001, 4'b0001, 16'h0001, 16'h9999, 16'h0100, 1'b1, 2'b00, 16'h0101, 16'h0043, 16'h0100, 3'b000, 3'd0, 3'd1, 3'd2));
        vecs.push_back(mk(16'h7A83, 16'h0000, 6'b001001, 4'b0000, 16'h4000, 16'hBEEF, 16'h0000, 1'b1, 2'b10, 16'h4003, 16'h4003, 16'hBEEF, 3'b000, 3'd5, 3'd2, 3'd5));
        vecs.push_back(mk(16'h3600, 16'h2000, 6'b000111, 4'b0010, 16'h0000, 16'h0000, 16'h0000, 1'b1, 2'b01, 16'h2000, 16'h2000, 16'h4003, 3'b000, 3'd3, 3'd0, 3'd3));
        vecs.push_back(mk(16'hB5C5, 16'h0100, 6'b000110, 4'b0000, 16'h0000, 16'h1111, 16'h0000, 1'b0, 2'b11, 16'h00C5, 16'h00C5, 16'h1111, 3'b000, 3'd2, 3'd7, 3'd2));

        // Reset with random inputs; sr1/sr2 still follow IR.
        reset = 1'b0; enable_execute = 1'b1; IR = 16'h7A83;
        randomize_inputs();
        repeat (2) begin
            @(posedge clock); #1;
            randomize_inputs();
        end
        chk_zero("reset");
        chk("reset.sr1", {13'h0, sr1}, 16'd2);
        chk("reset.sr2", {13'h0, sr2}, 16'd5);

        @(negedge clock);
        reset = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clock); #1;
            chk($sformatf("v%0d.sr1", i), {13'h0, sr1}, {13'h0, vecs[i].e_sr1});
            chk($sformatf("v%0d.sr2", i), {13'h0, sr2}, {13'h0, vecs[i].e_sr2});
            chk($sformatf("v%0d.aluout", i), aluout, vecs[i].e_alu);
            chk($sformatf("v%0d.pcout", i), pcout, vecs[i].e_pc);
            chk($sformatf("v%0d.M_Data", i), M_Data, vecs[i].e_md);
            chk($sformatf("v%0d.NZP", i), {13'h0, NZP}, {13'h0, vecs[i].e_nzp});
            chk($sformatf("v%0d.dr", i), {13'h0, dr}, {13'h0, vecs[i].e_dr});
            chk($sformatf("v%0d.IR_Exec", i), IR_Exec, vecs[i].ir);
            chk($sformatf("v%0d.Mem_Control_out", i), {15'h0, Mem_Control_out}, {15'h0, vecs[i].mem});
            chk($sformatf("v%0d.W_Control_out", i), {14'h0, W_Control_out}, {14'h0, vecs[i].wc});
        end

        // Branch, then a 3-cycle stall with changing inputs.
        drive(mk(16'h0E05, 16'h3001, 6'b000110, 4'b0000, 16'h0000, 16'h2222, 16'h0000, 1'b1, 2'b10,
                 16'h0, 16'h0, 16'h0, 3'b0, 3'd0, 3'd0, 3'd0));
        @(posedge clock); #1;
        chk("br.pcout", pcout, 16'h3006);
        chk("br.aluout", aluout, 16'h3006);
        chk("br.NZP", {13'h0, NZP}, 16'h0007);
        enable_execute = 1'b0;
        for (int k = 0; k < 3; k++) begin
            IR = 16'h1042 + 16'(k); VSR1 = 16'(k * 7); VSR2 = 16'h5A5A; npc_in = 16'h0;
            E_control = 6'b000001; Mem_Control_in = 1'b0; W_Control_in = 2'b01;
            @(posedge clock); #1;
            chk($sformatf("stall%0d.NZP", k), {13'h0, NZP}, 16'h0000);
            chk($sformatf("stall%0d.aluout", k), aluout, 16'h3006);
            chk($sformatf("stall%0d.pcout", k), pcout, 16'h3006);
            chk($sformatf("stall%0d.IR_Exec", k), IR_Exec, 16'h0E05);
            chk($sformatf("stall%0d.dr", k), {13'h0, dr}, 16'h0007);
            chk($sformatf("stall%0d.M_Data", k), M_Data, 16'h2222);
            chk($sformatf("stall%0d.Mem_Control_out", k), {15'h0, Mem_Control_out}, 16'h0001);
            chk($sformatf("stall%0d.W_Control_out", k), {14'h0, W_Control_out}, 16'h0002);
        end
        enable_execute = 1'b1;
        IR = 16'h1042; VSR1 = 16'h0005; VSR2 = 16'h0003;
        @(posedge clock); #1;
        chk("resume.aluout", aluout, 16'h0008);
        chk("resume.IR_Exec", IR_Exec, 16'h1042);
        chk("resume.W_Control_out", {14'h0, W_Control_out}, 16'h0001);

        // Mid-stream reset overrides enable.
        reset = 1'b0;
        @(posedge clock); #1;
        chk_zero("midreset");
        reset = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
